// File: rtl/mod_ser2par_pkg.sv
// Shared types and helpers for the serial-to-parallel collector.
package mod_ser2par_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } bank_state_t;

  localparam int WORD_W = 8;
  typedef logic [WORD_W-1:0] word_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mod_ser2par_bank.sv
// One N-lane collection bank: lane registers, write pointer and FILL/HOLD state.
module mod_ser2par_bank
  import mod_ser2par_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [W-1:0]              wr_data,
  input  logic                      rd_en,
  output logic                      full,
  output logic [N-1:0][W-1:0]       data,
  output logic [$clog2(N+1)-1:0]    count
);

  localparam int CNT_W = cnt_w(N);

  bank_state_t      state, state_nxt;
  logic [CNT_W-1:0] ptr;
  logic             last;

  assign last  = (ptr == CNT_W'(N - 1));
  assign full  = (state == HOLD);
  assign count = full ? CNT_W'(N) : ptr;

  always_ff @(posedge clk) begin
    if (!resetn) state <= FILL;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (wr_en && last) state_nxt = HOLD;
        HOLD:    if (rd_en)         state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  // ptr parks at N-1 while holding; only read, clr or reset rewind it
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      ptr <= '0;
    end else if (state == HOLD) begin
      if (rd_en) ptr <= '0;
    end else if (wr_en && !last) begin
      ptr <= ptr + CNT_W'(1);
    end
  end

  // lanes survive reads and clr; only reset zeroes them
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data <= '0;
    end else if (!clr && wr_en && state == FILL) begin
      for (int k = 0; k < N; k++)
        if (ptr == CNT_W'(k)) data[k] <= wr_data;
    end
  end

endmodule

// File: rtl/mod_ser2par_buf.sv
// Serial-to-parallel collector: packs N W-bit words into one vector with valid/ready on both sides.
// Define MOD_SER2PAR_DBUF_EN for ping-pong double buffering (two banks).
module mod_ser2par_buf
  import mod_ser2par_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      clr,
  input  logic                      i_valid,
  input  logic [W-1:0]              i_data,
  output logic                      i_ready,
  output logic                      o_valid,
  output logic [N-1:0][W-1:0]       o_data,
  input  logic                      o_ready,
  output logic [$clog2(N+1)-1:0]    count,
  output logic                      reg_full
);

  localparam int CNT_W = cnt_w(N);

  if (N < 2) begin : g_bad_n
    $error("mod_ser2par_buf: N must be >= 2");
  end

  logic acc, rd;
  assign acc = i_valid && i_ready && !clr;
  assign rd  = o_valid && o_ready && !clr;

`ifdef MOD_SER2PAR_DBUF_EN
  logic [1:0]                  full;
  logic [1:0][N-1:0][W-1:0]    data;
  logic [1:0][CNT_W-1:0]       cnt;
  logic                        wr_sel, rd_sel;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    mod_ser2par_bank #(.N(N), .W(W)) u_bank (
      .clk     (clk),
      .resetn  (resetn),
      .clr     (clr),
      .wr_en   (acc && (wr_sel == 1'(b))),
      .wr_data (i_data),
      .rd_en   (rd && (rd_sel == 1'(b))),
      .full    (full[b]),
      .data    (data[b]),
      .count   (cnt[b])
    );
  end

  assign i_ready  = resetn && !full[wr_sel];
  assign o_valid  = full[rd_sel];
  assign o_data   = data[rd_sel];
  assign count    = cnt[wr_sel];
  assign reg_full = &full;

  // banks complete and drain in strict alternation, so one toggle bit per side suffices
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      if (acc && cnt[wr_sel] == CNT_W'(N - 1)) wr_sel <= ~wr_sel;
      if (rd) rd_sel <= ~rd_sel;
    end
  end
`else
  logic bank_full;

  mod_ser2par_bank #(.N(N), .W(W)) u_bank (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (clr),
    .wr_en   (acc),
    .wr_data (i_data),
    .rd_en   (rd),
    .full    (bank_full),
    .data    (o_data),
    .count   (count)
  );

  assign i_ready  = resetn && !bank_full;
  assign o_valid  = bank_full;
  assign reg_full = bank_full;
`endif

endmodule
